// File: rtl/packer_fsm_if.sv
// Beat and wide-word handshake bundle between the upstream beat source,
// packer_fsm and the downstream unpacker.
interface packer_fsm_if;
    // Upstream beat bus (32-byte beats)
    logic          val;
    logic          sop;
    logic          eop;
    logic [7:0]    vbc;
    logic [255:0]  data;
    logic          ready;

    // Downstream wide-word bus (5 slots x 32 bytes)
    logic          o_val;
    logic          o_sop;
    logic          o_eop;
    logic [7:0]    o_vbc;
    logic [1279:0] o_data;
    logic          o_ready;

    // Environment side: drives beats, accepts wide words
    modport master (
        output val, sop, eop, vbc, data, o_ready,
        input  ready, o_val, o_sop, o_eop, o_vbc, o_data
    );

    // Packer side: accepts beats, drives wide words
    modport slave (
        input  val, sop, eop, vbc, data, o_ready,
        output ready, o_val, o_sop, o_eop, o_vbc, o_data
    );
endinterface

// File: rtl/packer_fsm.sv
// Packs up to five 32-byte beats into one 160-byte wide word for the
// unpacker. The first beat of a word ends up in the highest used slot and
// the last beat in slot 0. A completed word that cannot enter the busy
// output register parks in the accumulator (FLUSH) and stalls upstream.
module packer_fsm (
    input  logic        clk,
    input  logic        reset,
    packer_fsm_if.slave bus,
    output logic        idle,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    state_t        state;
    logic [1279:0] acc_data;
    logic [2:0]    acc_cnt;
    logic [7:0]    acc_vbc;
    logic          acc_sop;
    logic          acc_eop;   // eop of a completed word parked in FLUSH

    logic          accept;
    logic          out_free;
    logic          beat_ok;
    logic          bad;
    logic [7:0]    eff_vbc;
    logic [1279:0] base_data;
    logic [2:0]    base_cnt;
    logic [7:0]    base_vbc;
    logic          base_sop;
    logic [1279:0] nxt_data;
    logic [2:0]    nxt_cnt;
    logic [7:0]    nxt_vbc;
    logic          nxt_sop;
    logic          complete;

    // Upstream is stalled while reset is high and while a word is parked.
    assign bus.ready = !reset && (state != FLUSH);
    assign idle      = (state == IDLE) && !bus.o_val;

    // Classify the presented beat and build the accumulator content it produces.
    always_comb begin
        // NOTE: every signal gets a value on every path here, so no latch is inferred.
        accept   = bus.val && bus.ready;
        out_free = !bus.o_val || bus.o_ready;
        // Zero-length beats and beats outside an open packet are dropped.
        beat_ok  = accept && (bus.vbc != 8'd0) && (bus.sop || state == ACCUM);
        bad      = (accept && !beat_ok)
                || (beat_ok && bus.sop && state == ACCUM)
                || (beat_ok && !bus.eop && bus.vbc != 8'd32)
                || (beat_ok && bus.vbc > 8'd32);
        // Only the last beat of a packet may be short; oversize counts all 32 bytes.
        eff_vbc  = (!bus.eop || bus.vbc > 8'd32) ? 8'd32 : bus.vbc;
        // A sop beat always starts from an empty accumulator (discarding any open packet).
        if (bus.sop) begin
            base_data = '0;
            base_cnt  = 3'd0;
            base_vbc  = 8'd0;
            base_sop  = 1'b0;
        end else begin
            base_data = acc_data;
            base_cnt  = acc_cnt;
            base_vbc  = acc_vbc;
            base_sop  = acc_sop;
        end
        nxt_data = {base_data[1023:0], bus.data};
        nxt_cnt  = base_cnt + 3'd1;
        nxt_vbc  = base_vbc + eff_vbc;
        nxt_sop  = base_sop | bus.sop;
        complete = bus.eop || (nxt_cnt == 3'd5);
    end

    // Packing FSM with registered output word, accumulator and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the wide data registers are reset too, so o_data reads 0 after reset.
            state      <= IDLE;
            acc_data   <= '0;
            acc_cnt    <= 3'd0;
            acc_vbc    <= 8'd0;
            acc_sop    <= 1'b0;
            acc_eop    <= 1'b0;
            bus.o_val  <= 1'b0;
            bus.o_sop  <= 1'b0;
            bus.o_eop  <= 1'b0;
            bus.o_vbc  <= 8'd0;
            bus.o_data <= '0;
            err        <= 1'b0;
        end else begin
            err <= bad;
            // A transferred word leaves unless a new word is loaded below.
            if (bus.o_ready) begin
                bus.o_val <= 1'b0;
            end
            case (state)
                IDLE, ACCUM: begin
                    if (beat_ok) begin
                        if (complete && out_free) begin
                            bus.o_val  <= 1'b1;
                            bus.o_sop  <= nxt_sop;
                            bus.o_eop  <= bus.eop;
                            bus.o_vbc  <= nxt_vbc;
                            bus.o_data <= nxt_data;
                            acc_data   <= '0;
                            acc_cnt    <= 3'd0;
                            acc_vbc    <= 8'd0;
                            acc_sop    <= 1'b0;
                            state      <= bus.eop ? IDLE : ACCUM;
                        end else if (complete) begin
                            acc_data <= nxt_data;
                            acc_cnt  <= nxt_cnt;
                            acc_vbc  <= nxt_vbc;
                            acc_sop  <= nxt_sop;
                            acc_eop  <= bus.eop;
                            state    <= FLUSH;
                        end else begin
                            acc_data <= nxt_data;
                            acc_cnt  <= nxt_cnt;
                            acc_vbc  <= nxt_vbc;
                            acc_sop  <= nxt_sop;
                            state    <= ACCUM;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        bus.o_val  <= 1'b1;
                        bus.o_sop  <= acc_sop;
                        bus.o_eop  <= acc_eop;
                        bus.o_vbc  <= acc_vbc;
                        bus.o_data <= acc_data;
                        acc_data   <= '0;
                        acc_cnt    <= 3'd0;
                        acc_vbc    <= 8'd0;
                        acc_sop    <= 1'b0;
                        acc_eop    <= 1'b0;
                        state      <= acc_eop ? IDLE : ACCUM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_packer_fsm.sv
// Directed bench for packer_fsm: expected wide words are queued when the
// completing beat is driven and compared when the DUT transfers a word.
module tb_packer_fsm;
    typedef struct {
        logic          sop;
        logic          eop;
        logic [7:0]    vbc;
        logic [1279:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic idle;
    logic err;
    int   checks = 0;
    int   errors = 0;
    int   ready_low = 0;
    exp_t q[$];

    packer_fsm_if bus ();

    packer_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .idle  (idle),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input int k);
        logic [31:0] w;
        w = 32'hA5C3_0000 + k;
        return {8{w}};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic s, input logic e, input logic [7:0] v, input logic [1279:0] d);
        exp_t x;
        x.sop  = s;
        x.eop  = e;
        x.vbc  = v;
        x.data = d;
        q.push_back(x);
    endtask

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic s, input logic e, input logic [7:0] v, input logic [255:0] d);
        int n;
        n = 0;
        bus.val  = 1'b1;
        bus.sop  = s;
        bus.eop  = e;
        bus.vbc  = v;
        bus.data = d;
        @(negedge clk);
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_timeout", (n < 100) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.val = 1'b0;
        bus.sop = 1'b0;
        bus.eop = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count cycles in which upstream is stalled outside reset.
    always @(negedge clk) begin
        if (!reset && !bus.ready) ready_low++;
    end

    // Scoreboard: pop and compare on every transfer; check held words stay stable.
    logic          held = 1'b0;
    logic [7:0]    prev_vbc;
    logic [1279:0] prev_data;
    always @(negedge clk) begin
        exp_t e;
        int   slot;
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_o_val", {31'd0, bus.o_val}, 32'd1);
                check("hold_o_vbc", {24'd0, bus.o_vbc}, {24'd0, prev_vbc});
                checks++;
                assert (bus.o_data === prev_data) else begin
                    errors++;
                    $error("FAIL hold_o_data observed_low=%h expected_low=%h", bus.o_data[255:0], prev_data[255:0]);
                end
            end
            if (bus.o_val && bus.o_ready) begin
                checks++;
                assert (q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_word observed_vbc=%0d expected=none", bus.o_vbc);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("word_sop", {31'd0, bus.o_sop}, {31'd0, e.sop});
                    check("word_eop", {31'd0, bus.o_eop}, {31'd0, e.eop});
                    check("word_vbc", {24'd0, bus.o_vbc}, {24'd0, e.vbc});
                    slot = -1;
                    for (int s = 4; s >= 0; s--) begin
                        if (bus.o_data[s*256 +: 256] !== e.data[s*256 +: 256]) slot = s;
                    end
                    checks++;
                    assert (slot < 0) else begin
                        errors++;
                        $error("FAIL word_data slot=%0d observed=%h expected=%h",
                               slot, bus.o_data[slot*256 +: 256], e.data[slot*256 +: 256]);
                    end
                end
            end
            held      = bus.o_val && !bus.o_ready;
            prev_vbc  = bus.o_vbc;
            prev_data = bus.o_data;
        end
    end

    initial begin
        int rl;
        int n;
        reset       = 1'b1;
        bus.val     = 1'b0;
        bus.sop     = 1'b0;
        bus.eop     = 1'b0;
        bus.vbc     = 8'd0;
        bus.data    = '0;
        bus.o_ready = 1'b1;

        // Reset state
        cycles(3);
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_o_val", {31'd0, bus.o_val}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, bus.ready}, 32'd1);
        check("post_rst_o_vbc", {24'd0, bus.o_vbc}, 32'd0);
        check("post_rst_o_data", {31'd0, |bus.o_data}, 32'd0);
        @(posedge clk);
        #1;

        // Single-beat packet, one-cycle latency
        push(1'b1, 1'b1, 8'd20, {1024'd0, pat(1)});
        send(1'b1, 1'b1, 8'd20, pat(1));
        check("single_latency_o_val", {31'd0, bus.o_val}, 32'd1);
        cycles(2);

        // 70-byte packet: 32, 32, 6
        push(1'b1, 1'b1, 8'd70, {512'd0, pat(2), pat(3), pat(4)});
        send(1'b1, 1'b0, 8'd32, pat(2));
        send(1'b0, 1'b0, 8'd32, pat(3));
        send(1'b0, 1'b1, 8'd6, pat(4));
        cycles(2);

        // 200-byte packet: six beats of 32 then 8, upstream never stalled
        rl = ready_low;
        push(1'b1, 1'b0, 8'd160, {pat(10), pat(11), pat(12), pat(13), pat(14)});
        push(1'b0, 1'b1, 8'd40, {768'd0, pat(15), pat(16)});
        send(1'b1, 1'b0, 8'd32, pat(10));
        for (int i = 11; i <= 15; i++) send(1'b0, 1'b0, 8'd32, pat(i));
        send(1'b0, 1'b1, 8'd8, pat(16));
        cycles(2);
        check("long_ready_stalls", ready_low - rl, 32'd0);

        // Backpressure: two single-beat packets into a blocked output
        bus.o_ready = 1'b0;
        push(1'b1, 1'b1, 8'd10, {1024'd0, pat(20)});
        push(1'b1, 1'b1, 8'd12, {1024'd0, pat(21)});
        send(1'b1, 1'b1, 8'd10, pat(20));
        send(1'b1, 1'b1, 8'd12, pat(21));
        @(negedge clk);
        check("bp_flush_ready", {31'd0, bus.ready}, 32'd0);
        check("bp_o_val", {31'd0, bus.o_val}, 32'd1);
        check("bp_first_vbc", {24'd0, bus.o_vbc}, 32'd10);
        cycles(3);
        bus.o_ready = 1'b1;
        cycles(3);
        check("bp_ready_back", {31'd0, bus.ready}, 32'd1);
        check("bp_drained", q.size(), 32'd0);

        // Non-sop beat in IDLE: dropped with err pulse
        send(1'b0, 1'b1, 8'd7, pat(30));
        check("err_nosop_pulse", {31'd0, err}, 32'd1);
        cycles(1);
        check("err_nosop_clear", {31'd0, err}, 32'd0);
        check("err_nosop_no_out", {31'd0, bus.o_val}, 32'd0);

        // Zero-length beat: dropped with err pulse
        send(1'b1, 1'b1, 8'd0, pat(31));
        check("err_vbc0_pulse", {31'd0, err}, 32'd1);
        cycles(2);

        // Short non-eop beat counted as 32 bytes
        push(1'b1, 1'b1, 8'd40, {768'd0, pat(32), pat(33)});
        send(1'b1, 1'b0, 8'd16, pat(32));
        check("err_short_pulse", {31'd0, err}, 32'd1);
        send(1'b0, 1'b1, 8'd8, pat(33));
        check("err_short_eop_ok", {31'd0, err}, 32'd0);
        cycles(2);

        // sop in ACCUM: open packet discarded, restarts with new beat
        push(1'b1, 1'b1, 8'd9, {1024'd0, pat(41)});
        send(1'b1, 1'b0, 8'd32, pat(40));
        send(1'b1, 1'b1, 8'd9, pat(41));
        check("err_resop_pulse", {31'd0, err}, 32'd1);
        cycles(2);

        // Reset after 2 of 4 beats: partial packet lost
        send(1'b1, 1'b0, 8'd32, pat(50));
        send(1'b0, 1'b0, 8'd32, pat(51));
        reset = 1'b1;
        cycles(1);
        check("midrst_ready", {31'd0, bus.ready}, 32'd0);
        check("midrst_o_val", {31'd0, bus.o_val}, 32'd0);
        check("midrst_o_vbc", {24'd0, bus.o_vbc}, 32'd0);
        check("midrst_idle", {31'd0, idle}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_ready_after", {31'd0, bus.ready}, 32'd1);
        push(1'b1, 1'b1, 8'd5, {1024'd0, pat(52)});
        send(1'b1, 1'b1, 8'd5, pat(52));

        // Drain the scoreboard within a bounded time
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        cycles(2);
        check("final_drained", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
